// File: rtl/fft_8point_16bit.sv
// fft_8point_16bit
//   8-point radix-2 decimation-in-time FFT over a fixed internal sample table
//   x[n] = n (Q8.8, real). One butterfly stage per clock, all four butterflies
//   of a stage in parallel. Twiddles are Q1.14; every twiddle product is
//   rounded back to Q8.8. Add/sub wraps in 16 bits with no scaling.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      launches one transform, only honoured in IDLE
//   r0..r7     Re X[k], signed Q8.8, registered, natural order
//   i0..i7     Im X[k], signed Q8.8, registered, natural order
//
// Timing: start sampled at edge E -> LOAD, S1, S2, S3; results land at E+4.
module fft_8point_16bit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7,
    output logic [15:0] i0, i1, i2, i3, i4, i5, i6, i7
);

    typedef enum logic [2:0] {IDLE, LOAD, S1, S2, S3} state_t;

    // Samples already in bit-reversed slot order (slot 0 at the LSB end):
    // slots 0..7 hold x[0],x[4],x[2],x[6],x[1],x[5],x[3],x[7].
    localparam logic [7:0][15:0] SAMPLES_BR = {
        16'h0700, 16'h0300, 16'h0500, 16'h0100,
        16'h0600, 16'h0200, 16'h0400, 16'h0000
    };

    localparam logic signed [15:0] TW_RE [4] = '{16'sd16384,  16'sd11585,  16'sd0,     -16'sd11585};
    localparam logic signed [15:0] TW_IM [4] = '{16'sd0,     -16'sd11585, -16'sd16384, -16'sd11585};

    state_t state_q, state_d;
    logic [7:0][15:0] re_q, im_q;          // working stage registers
    logic [7:0][15:0] bf_re, bf_im;        // combinational stage result
    logic [7:0][15:0] out_re_q, out_im_q;  // published results
    logic             ld, wr, adv;
    logic [1:0]       sel;

    // Q8.8 x Q1.14 -> Q8.8 with round-half-up.
    function automatic logic [15:0] tmul(input logic signed [15:0] a,
                                         input logic signed [15:0] w);
        logic signed [31:0] p;
        p = a * w;
        p = p + 32'sd8192;
        p = p >>> 14;
        return p[15:0];
    endfunction

    // One DIT stage. sel 0/1/2 -> butterfly span 1/2/4. For butterfly b,
    // the top index, its partner and the twiddle exponent follow directly
    // from the bits of b, which avoids any division in hardware.
    function automatic void bfly(input  logic [7:0][15:0] ir, ii,
                                 input  logic [1:0]       s,
                                 output logic [7:0][15:0] or_, oi);
        logic [2:0]  top, bot;
        logic [1:0]  w, bb;
        logic [15:0] tr, ti;
        or_ = ir;
        oi  = ii;
        for (int b = 0; b < 4; b++) begin
            bb = 2'(b);
            case (s)
                2'd0:    begin top = {bb, 1'b0};           bot = top | 3'd1; w = 2'd0;          end
                2'd1:    begin top = {bb[1], 1'b0, bb[0]}; bot = top | 3'd2; w = {bb[0], 1'b0}; end
                default: begin top = {1'b0, bb};           bot = top | 3'd4; w = bb;            end
            endcase
            tr = tmul(ir[bot], TW_RE[w]) - tmul(ii[bot], TW_IM[w]);
            ti = tmul(ir[bot], TW_IM[w]) + tmul(ii[bot], TW_RE[w]);
            or_[top] = ir[top] + tr;
            oi[top]  = ii[top] + ti;
            or_[bot] = ir[top] - tr;
            oi[bot]  = ii[top] - ti;
        end
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    state_d = S1;
            S1:      state_d = S2;
            S2:      state_d = S3;
            S3:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath controls
    always_comb begin
        ld  = (state_q == LOAD);
        adv = (state_q == S1) || (state_q == S2);
        wr  = (state_q == S3);
        case (state_q)
            S1:      sel = 2'd0;
            S2:      sel = 2'd1;
            default: sel = 2'd2;
        endcase
    end

    always_comb begin
        bfly(re_q, im_q, sel, bf_re, bf_im);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            re_q <= '0;
            im_q <= '0;
        end else if (ld) begin
            re_q <= SAMPLES_BR;
            im_q <= '0;
        end else if (adv) begin
            re_q <= bf_re;
            im_q <= bf_im;
        end
    end

    // Last stage goes straight to the outputs, so they only ever change
    // with a complete result.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_re_q <= '0;
            out_im_q <= '0;
        end else if (wr) begin
            out_re_q <= bf_re;
            out_im_q <= bf_im;
        end
    end

    assign r0 = out_re_q[0]; assign i0 = out_im_q[0];
    assign r1 = out_re_q[1]; assign i1 = out_im_q[1];
    assign r2 = out_re_q[2]; assign i2 = out_im_q[2];
    assign r3 = out_re_q[3]; assign i3 = out_im_q[3];
    assign r4 = out_re_q[4]; assign i4 = out_im_q[4];
    assign r5 = out_re_q[5]; assign i5 = out_im_q[5];
    assign r6 = out_re_q[6]; assign i6 = out_im_q[6];
    assign r7 = out_re_q[7]; assign i7 = out_im_q[7];

endmodule

// File: tb/tb_fft_8point_16bit.sv
// Directed bench for fft_8point_16bit: reset state, nominal transform and
// latency, reset mid-transform, start while busy, start held high, reset
// after a result, and conjugate symmetry of the spectrum.
module tb_fft_8point_16bit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;
    logic [15:0] i0, i1, i2, i3, i4, i5, i6, i7;

    fft_8point_16bit dut (
        .clk(clk), .rst(rst), .start(start),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
        .i0(i0), .i1(i1), .i2(i2), .i3(i3), .i4(i4), .i5(i5), .i6(i6), .i7(i7)
    );

    always #5 clk = ~clk;

    logic [15:0] obs_r [8];
    logic [15:0] obs_i [8];
    always_comb begin
        obs_r[0] = r0; obs_r[1] = r1; obs_r[2] = r2; obs_r[3] = r3;
        obs_r[4] = r4; obs_r[5] = r5; obs_r[6] = r6; obs_r[7] = r7;
        obs_i[0] = i0; obs_i[1] = i1; obs_i[2] = i2; obs_i[3] = i3;
        obs_i[4] = i4; obs_i[5] = i5; obs_i[6] = i6; obs_i[7] = i7;
    end

    // X[k] of x[n]=n: X0 = 28, Xk = -4 + j*4*cot(pi*k/8), in Q8.8.
    localparam logic [15:0] EXP_R [8] = '{16'h1C00, 16'hFC00, 16'hFC00, 16'hFC00,
                                          16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00};
    localparam logic [15:0] EXP_I [8] = '{16'h0000, 16'h09A8, 16'h0400, 16'h01A8,
                                          16'h0000, 16'hFE58, 16'hFC00, 16'hF658};

    int errors = 0;
    int checks = 0;

    function automatic int sdiff(input logic [15:0] a, input logic [15:0] b);
        int d;
        d = int'($signed(a)) - int'($signed(b));
        return (d < 0) ? -d : d;
    endfunction

    // Drive start so the next edge samples it; returns just after that edge.
    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (obs_r[k] !== 16'h0000 || obs_i[k] !== 16'h0000) begin
                errors++;
                $display("FAIL reset_state k=%0d: got r=%h i=%h want 0000/0000", k, obs_r[k], obs_i[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        pulse_start();                      // now just after E
        @(posedge clk); #1 rst = 1'b1;      // sampled at E+2
        @(posedge clk); #1 rst = 1'b0;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (obs_r[k] !== 16'h0000 || obs_i[k] !== 16'h0000) begin
                    errors++;
                    $display("FAIL reset_mid cyc=%0d k=%0d: got r=%h i=%h want 0000/0000", c, k, obs_r[k], obs_i[k]);
                end
            end
        end
    endtask

    task automatic test_nominal();
        pulse_start();
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (obs_r[k] !== 16'h0000 || obs_i[k] !== 16'h0000) begin
                    errors++;
                    $display("FAIL nominal_early E+%0d k=%0d: got r=%h i=%h want 0000/0000", e, k, obs_r[k], obs_i[k]);
                end
            end
        end
        @(posedge clk); #1;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (sdiff(obs_r[k], EXP_R[k]) > 2 || sdiff(obs_i[k], EXP_I[k]) > 2) begin
                errors++;
                $display("FAIL nominal_value k=%0d: got r=%h i=%h want %h/%h", k, obs_r[k], obs_i[k], EXP_R[k], EXP_I[k]);
            end
        end
    endtask

    task automatic test_symmetry();
        for (int k = 1; k <= 3; k++) begin
            checks++;
            if (sdiff(obs_r[k], obs_r[8-k]) > 2 || sdiff(obs_i[k], 16'(-int'($signed(obs_i[8-k])))) > 2) begin
                errors++;
                $display("FAIL symmetry k=%0d: got r=%h/%h i=%h/%h want conjugate pair", k, obs_r[k], obs_r[8-k], obs_i[k], obs_i[8-k]);
            end
        end
    endtask

    task automatic test_reset_after_result();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (obs_r[k] !== 16'h0000 || obs_i[k] !== 16'h0000) begin
                errors++;
                $display("FAIL reset_after_result k=%0d: got r=%h i=%h want 0000/0000", k, obs_r[k], obs_i[k]);
            end
        end
    endtask

    task automatic test_busy_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk);                     // E
        repeat (3) @(posedge clk);          // start also high at E+1..E+3
        #1 start = 1'b0;
        // still inside the transform: outputs untouched after E+3
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (obs_r[k] !== 16'h0000 || obs_i[k] !== 16'h0000) begin
                errors++;
                $display("FAIL busy_early k=%0d: got r=%h i=%h want 0000/0000", k, obs_r[k], obs_i[k]);
            end
        end
        for (int c = 4; c <= 12; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (sdiff(obs_r[k], EXP_R[k]) > 2 || sdiff(obs_i[k], EXP_I[k]) > 2) begin
                    errors++;
                    $display("FAIL busy_value E+%0d k=%0d: got r=%h i=%h want %h/%h", c, k, obs_r[k], obs_i[k], EXP_R[k], EXP_I[k]);
                end
            end
        end
    endtask

    task automatic test_start_held();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; start = 1'b1;
        @(posedge clk); #1;                 // E
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (obs_r[k] !== 16'h0000 || obs_i[k] !== 16'h0000) begin
                    errors++;
                    $display("FAIL held_early E+%0d k=%0d: got r=%h i=%h want 0000/0000", e, k, obs_r[k], obs_i[k]);
                end
            end
        end
        // Three full periods of back-to-back transforms, sampled every cycle.
        for (int c = 4; c <= 19; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (sdiff(obs_r[k], EXP_R[k]) > 2 || sdiff(obs_i[k], EXP_I[k]) > 2) begin
                    errors++;
                    $display("FAIL held_value E+%0d k=%0d: got r=%h i=%h want %h/%h", c, k, obs_r[k], obs_i[k], EXP_R[k], EXP_I[k]);
                end
            end
        end
        start = 1'b0;
        repeat (6) @(posedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not complete within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_reset_mid();
        test_nominal();
        test_symmetry();
        test_reset_after_result();
        test_busy_start();
        test_start_held();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fft_8point_16bit.md
FFT_8POINT_16BIT -- requirements
Module: fft_8point_16bit

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 SHALL have ports, listed as name, direction, width, meaning:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  starts one transform; sampled in IDLE only.
- r0..r7  output  16 each  Re X[k], signed Q8.8, registered.
- i0..i7  output  16 each  Im X[k], signed Q8.8, registered.
REQ-003 SHALL have no data inputs; the 8 input samples come from an internal constant table.

Function
REQ-004 SHALL compute an 8-point DFT: X[k] = sum over n of x[n]*W8^(nk), with W8 = exp(-j*2*pi/8).
REQ-005 SHALL use an internal sample table x[n] = n for n = 0..7, real-valued, Q8.8 (0x0000, 0x0100, ..., 0x0700), with all imaginary parts 0.
REQ-006 SHALL implement radix-2 decimation-in-time:
- load the samples in bit-reversed order (0,4,2,6,1,5,3,7);
- run 3 butterfly stages, all 4 butterflies of a stage in one cycle.
REQ-007 SHALL use twiddles in signed Q1.14:
- W0 = (16384, 0)
- W1 = (11585, -11585)
- W2 = (0, -16384)
- W3 = (-11585, -11585)
REQ-008 SHALL form each twiddle product as a 16x16 signed multiply to 32 bits, add 2^13, then arithmetic-shift right by 14 to return to Q8.8.
REQ-009 SHALL compute butterfly add/sub in 16-bit two's complement, with no per-stage scaling and no saturation (wrap).
REQ-010 SHALL implement FSM states IDLE, LOAD, S1, S2, S3 with these transitions:
- IDLE -> LOAD when start=1;
- LOAD -> S1 -> S2 -> S3, one clock each;
- S3 -> IDLE; on that edge the S3 results are written to r0..r7/i0..i7.
REQ-011 SHALL have latency 4 clocks: if start is sampled 1 at edge E in IDLE, the outputs show the new result after edge E+4.
REQ-012 SHALL ignore start outside IDLE; a start held high re-triggers a transform on each return to IDLE.
REQ-013 SHALL hold the outputs constant between result writes, never showing intermediate stage values.
REQ-014 SHALL order outputs naturally: r_k/i_k = X[k] for k = 0..7.

Reset
REQ-015 SHALL on rst=1 at a clock edge: FSM -> IDLE; all r*/i* and internal stage registers -> 0x0000.
REQ-016 SHALL give rst priority over start and over any in-progress transform; an interrupted transform produces no output write.
REQ-017 SHALL keep the outputs at 0 after reset until a transform completes.

Verification
REQ-018 SHALL verify the nominal transform against these values, each within +/-2 LSB:
- Stimulus: rst for 2 cycles, then start=1 for 1 cycle.
- Timing: outputs are all 0 for 3 edges after start, and update at the 4th.
- r0=0x1C00, i0=0x0000
- r1=0xFC00, i1=0x09A8
- r2=0xFC00, i2=0x0400
- r3=0xFC00, i3=0x01A8
- r4=0xFC00, i4=0x0000
- r5=0xFC00, i5=0xFE58
- r6=0xFC00, i6=0xFC00
- r7=0xFC00, i7=0xF658
REQ-019 SHALL verify reset mid-operation: start, then rst=1 at the 2nd edge after start -> all outputs stay 0x0000; a later start then yields the REQ-018 values.
REQ-020 SHALL verify start ignored while busy: pulse start again at edges E+1..E+3 -> exactly one result write at E+4, with unchanged values.
REQ-021 SHALL verify start held high continuously: outputs update every 5 cycles with identical REQ-018 values and no glitches.
REQ-022 SHALL verify reset after a result: rst=1 for one edge -> all 16 outputs 0x0000 on that edge.
REQ-023 SHALL verify conjugate symmetry: r_k = r_(8-k) and i_k = -i_(8-k) for k = 1..3, within 2 LSB.
